// File: rtl/weight_loader_m_axi_pkg.sv
// Shared constants and FSM state type for the weight-loader AXI read burst path.
package weight_loader_m_axi_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 512;
    localparam int unsigned BYTES              = DEFAULT_DATA_WIDTH / 8;
    localparam int unsigned BOUNDARY_4K        = 4096;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } burst_state_t;

    function automatic int unsigned bytes_of(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/weight_loader_wq_weight_mmap_m_axi_burst_calc.sv
// Combinational beat count for the next AR burst.
// Optional 4 KB page clipping enabled by WQ_WEIGHT_M_AXI_4K_SPLIT_EN.
module weight_loader_wq_weight_mmap_m_axi_burst_calc
    import weight_loader_m_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 64,
    parameter int unsigned LEN_WIDTH     = 32,
    parameter int unsigned MAX_BURST_LEN = 16,
    parameter int unsigned BEAT_BYTES    = BYTES
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  remaining,
    output logic [8:0]            beats
);

    localparam int unsigned OFF       = $clog2(BEAT_BYTES);
    localparam int unsigned PAGE_BITS = $clog2(BOUNDARY_4K);

    logic [LEN_WIDTH-1:0] capped;
    logic                 unused_addr;

    assign unused_addr = ^addr;

`ifdef WQ_WEIGHT_M_AXI_4K_SPLIT_EN
    // addr is beat-aligned, so the byte distance to the page end divides exactly
    logic [PAGE_BITS:0] page_left;
    logic [PAGE_BITS:0] to_boundary;

    always_comb begin
        page_left   = (PAGE_BITS+1)'(BOUNDARY_4K) - {1'b0, addr[PAGE_BITS-1:0]};
        to_boundary = page_left >> OFF;
    end
`endif

    always_comb begin
        capped = remaining;
        if (remaining > LEN_WIDTH'(MAX_BURST_LEN)) begin
            capped = LEN_WIDTH'(MAX_BURST_LEN);
        end
`ifdef WQ_WEIGHT_M_AXI_4K_SPLIT_EN
        if (capped > LEN_WIDTH'(to_boundary)) begin
            capped = LEN_WIDTH'(to_boundary);
        end
`endif
        beats = 9'(capped);
    end

endmodule

// File: rtl/weight_loader_wq_weight_mmap_m_axi_burst_rd.sv
// Splits a beat-length read request into AXI AR bursts with an outstanding-burst limit.
// 4 KB page splitting is selected by WQ_WEIGHT_M_AXI_4K_SPLIT_EN.
module weight_loader_wq_weight_mmap_m_axi_burst_rd
    import weight_loader_m_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned LEN_WIDTH       = 32,
    parameter int unsigned MAX_BURST_LEN   = 16,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_en,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic [7:0]            ar_len,
    input  logic                  rlast_done,
    output logic                  busy
);

    localparam int unsigned BEAT_BYTES = bytes_of(DATA_WIDTH);
    localparam int unsigned OFF        = $clog2(BEAT_BYTES);
    localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);

    burst_state_t          state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [OUT_W-1:0]      outstanding;
    logic [OUT_W-1:0]      outstanding_next;
    logic [8:0]            beats;
    logic                  ar_hs;
    logic                  retire;
    logic                  load;

    weight_loader_wq_weight_mmap_m_axi_burst_calc #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .LEN_WIDTH     (LEN_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .BEAT_BYTES    (BEAT_BYTES)
    ) u_calc (
        .addr      (addr),
        .remaining (remaining),
        .beats     (beats)
    );

    // addr/remaining describe what is left after the burst held on AR, so the
    // next burst can be loaded in the same cycle as the current handshake.
    always_comb begin
        ar_hs            = ar_valid & ar_ready;
        retire           = rlast_done & (outstanding != '0);
        outstanding_next = outstanding;
        if (ar_hs && !retire) begin
            outstanding_next = outstanding + OUT_W'(1);
        end else if (!ar_hs && retire) begin
            outstanding_next = outstanding - OUT_W'(1);
        end
        load = (state == ISSUE) && (remaining != '0) && (!ar_valid || ar_hs)
            && (outstanding_next != OUT_W'(MAX_OUTSTANDING));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            ar_valid    <= 1'b0;
            ar_addr     <= '0;
            ar_len      <= '0;
            addr        <= '0;
            remaining   <= '0;
            outstanding <= '0;
        end else if (clk_en) begin
            outstanding <= outstanding_next;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready && req_len != '0) begin
                        addr      <= req_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
                        remaining <= req_len;
                        state     <= ISSUE;
                        req_ready <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (load) begin
                        ar_valid  <= 1'b1;
                        ar_addr   <= addr;
                        ar_len    <= 8'(beats - 9'd1);
                        addr      <= addr + (ADDR_WIDTH'(beats) << OFF);
                        remaining <= remaining - LEN_WIDTH'(beats);
                    end else if (ar_hs) begin
                        ar_valid <= 1'b0;
                    end
                    if (remaining == '0 && (!ar_valid || ar_hs)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE) || (outstanding != '0);

endmodule

// File: tb/tb_weight_loader_wq_weight_mmap_m_axi_burst_rd.sv
// Directed bench for the AR burst splitter (MAX_OUTSTANDING=2); 4 KB expectations
// follow WQ_WEIGHT_M_AXI_4K_SPLIT_EN.
module tb_weight_loader_wq_weight_mmap_m_axi_burst_rd;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic [31:0] req_len = '0;
    logic        ar_valid;
    logic        ar_ready = 1'b1;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic        rlast_done;
    logic        busy;

    logic        retire_en = 1'b0;
    logic        rlast_auto = 1'b0;
    logic        rlast_manual = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] hs_addr[$];
    logic [7:0]  hs_len[$];
    int          hs_cyc[$];

    assign rlast_done = rlast_auto | rlast_manual;

    weight_loader_wq_weight_mmap_m_axi_burst_rd #(
        .ADDR_WIDTH      (64),
        .DATA_WIDTH      (512),
        .LEN_WIDTH       (32),
        .MAX_BURST_LEN   (16),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_addr    (ar_addr),
        .ar_len     (ar_len),
        .rlast_done (rlast_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // AR handshake monitor; optionally retires each burst one cycle later
    always @(posedge clk) begin
        bit hs;
        cyc++;
        hs = reset_n && clk_en && ar_valid && ar_ready;
        if (hs) begin
            hs_addr.push_back(ar_addr);
            hs_len.push_back(ar_len);
            hs_cyc.push_back(cyc);
        end
        #1 rlast_auto = retire_en && hs;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        ar_ready     = 1'b1;
        retire_en    = 1'b0;
        rlast_manual = 1'b0;
        clk_en       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        hs_addr.delete();
        hs_len.delete();
        hs_cyc.delete();
    endtask

    task automatic do_req(input logic [63:0] a, input logic [31:0] l, output bit ok);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        ok        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL reset_ar_valid: got %b expected 0", ar_valid); end
        checks++; if (ar_addr !== 64'h0) begin errors++; $display("FAIL reset_ar_addr: got %h expected 0", ar_addr); end
        checks++; if (ar_len !== 8'h0) begin errors++; $display("FAIL reset_ar_len: got %0d expected 0", ar_len); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_split();
        logic [63:0] exp_addr[3] = '{64'h000, 64'h400, 64'h800};
        logic [7:0]  exp_len[3]  = '{8'd15, 8'd15, 8'd7};
        bit ok;
        bit idle_ok;
        do_reset();
        retire_en = 1'b1;
        do_req(64'h3F, 32'd40, ok);
        wait_idle(100, idle_ok);
        checks++; if (!(ok && idle_ok)) begin errors++; $display("FAIL split_done: accepted %b idle %b expected 1 1", ok, idle_ok); end
        checks++; if (hs_addr.size() !== 3) begin errors++; $display("FAIL split_count: got %0d expected 3", hs_addr.size()); end
        for (int i = 0; i < 3; i++) begin
            if (hs_addr.size() > i) begin
                checks++; if (hs_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL split_addr%0d: got %h expected %h", i, hs_addr[i], exp_addr[i]); end
                checks++; if (hs_len[i] !== exp_len[i]) begin errors++; $display("FAIL split_len%0d: got %0d expected %0d", i, hs_len[i], exp_len[i]); end
            end
        end
        if (hs_cyc.size() >= 3) begin
            checks++; if (hs_cyc[1] - hs_cyc[0] !== 1) begin errors++; $display("FAIL b2b_gap1: got %0d expected 1", hs_cyc[1] - hs_cyc[0]); end
            checks++; if (hs_cyc[2] - hs_cyc[1] !== 1) begin errors++; $display("FAIL b2b_gap2: got %0d expected 1", hs_cyc[2] - hs_cyc[1]); end
        end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL split_req_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_4k_cross();
        bit ok;
        bit idle_ok;
`ifdef WQ_WEIGHT_M_AXI_4K_SPLIT_EN
        logic [63:0] exp_addr[2] = '{64'hF80, 64'h1000};
        logic [7:0]  exp_len[2]  = '{8'd1, 8'd1};
        int          exp_n = 2;
`else
        logic [63:0] exp_addr[2] = '{64'hF80, 64'h0};
        logic [7:0]  exp_len[2]  = '{8'd3, 8'd0};
        int          exp_n = 1;
`endif
        do_reset();
        retire_en = 1'b1;
        do_req(64'hF80, 32'd4, ok);
        wait_idle(60, idle_ok);
        checks++; if (!(ok && idle_ok)) begin errors++; $display("FAIL 4k_done: accepted %b idle %b expected 1 1", ok, idle_ok); end
        checks++; if (hs_addr.size() !== exp_n) begin errors++; $display("FAIL 4k_count: got %0d expected %0d", hs_addr.size(), exp_n); end
        for (int i = 0; i < 2; i++) begin
            if (i < exp_n && hs_addr.size() > i) begin
                checks++; if (hs_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL 4k_addr%0d: got %h expected %h", i, hs_addr[i], exp_addr[i]); end
                checks++; if (hs_len[i] !== exp_len[i]) begin errors++; $display("FAIL 4k_len%0d: got %0d expected %0d", i, hs_len[i], exp_len[i]); end
            end
        end
    endtask

    task automatic test_outstanding();
        bit ok;
        do_reset();
        do_req(64'h0, 32'd64, ok);
        repeat (12) @(posedge clk);
        #1;
        checks++; if (hs_addr.size() !== 2) begin errors++; $display("FAIL limit_count: got %0d expected 2", hs_addr.size()); end
        checks++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL limit_ar_valid: got %b expected 0", ar_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL limit_busy: got %b expected 1", busy); end
        rlast_manual = 1'b1;
        @(posedge clk);
        #1;
        rlast_manual = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (hs_addr.size() !== 3) begin errors++; $display("FAIL limit_after_retire: got %0d expected 3", hs_addr.size()); end
        if (hs_addr.size() > 2) begin
            checks++; if (hs_addr[2] !== 64'h800) begin errors++; $display("FAIL limit_addr3: got %h expected 800", hs_addr[2]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen;
        do_reset();
        ar_ready = 1'b0;
        do_req(64'h2000, 32'd16, ok);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ar_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_ar_valid_rise: got 0 expected 1"); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ar_valid !== 1'b1 || ar_addr !== 64'h2000 || ar_len !== 8'd15) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid %b addr %h len %0d expected 1 2000 15", i, ar_valid, ar_addr, ar_len);
            end
        end
        ar_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (hs_addr.size() !== 1) begin errors++; $display("FAIL bp_hs_count: got %0d expected 1", hs_addr.size()); end
        if (hs_addr.size() > 0) begin
            checks++; if (hs_addr[0] !== 64'h2000 || hs_len[0] !== 8'd15) begin errors++; $display("FAIL bp_hs_beat: got %h/%0d expected 2000/15", hs_addr[0], hs_len[0]); end
        end
    endtask

    task automatic test_zero_len();
        bit ok;
        bit busy_seen;
        do_reset();
        do_req(64'h100, 32'd0, ok);
        busy_seen = busy;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            busy_seen |= busy;
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL zero_accept: got %b expected 1", ok); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy_seen); end
        checks++; if (hs_addr.size() !== 0) begin errors++; $display("FAIL zero_ar_count: got %0d expected 0", hs_addr.size()); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_req_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        do_req(64'h0, 32'd48, ok);
        for (int i = 0; i < 20; i++) begin
            if (hs_addr.size() >= 2) break;
            @(posedge clk);
            #1;
        end
        checks++; if (hs_addr.size() !== 2) begin errors++; $display("FAIL mid_pre_count: got %0d expected 2", hs_addr.size()); end
        reset_n = 1'b0;
        clk_en  = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL mid_ar_valid: got %b expected 0", ar_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_req_ready: got %b expected 1", req_ready); end
        reset_n = 1'b1;
        clk_en  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (hs_addr.size() !== 2) begin errors++; $display("FAIL mid_post_count: got %0d expected 2", hs_addr.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_post_busy: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_split();
        test_4k_cross();
        test_outstanding();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_loader_wq_weight_mmap_m_axi_burst_rd.md
WEIGHT_LOADER_WQ_WEIGHT_MMAP_M_AXI_BURST_RD -- requirements
Module: weight_loader_wq_weight_mmap_m_axi_burst_rd

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64: byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512: AXI data width in bits; BYTES = DATA_WIDTH/8.
REQ-003 SHALL have parameter LEN_WIDTH, default 32: width of the request length field, in beats.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 16: maximum beats per AR burst (1..256).
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 16: maximum number of issued AR bursts not yet retired.
REQ-006 SHALL have port clk  in  1  clock; one clock domain; all logic on the rising edge.
REQ-007 SHALL have port reset_n  in  1  reset; synchronous, active-low.
REQ-008 SHALL have port clk_en  in  1  global enable; when 0, all state holds.
REQ-009 SHALL have ports req_valid in 1, req_ready out 1, req_addr in ADDR_WIDTH, req_len in LEN_WIDTH: read request, length in beats.
REQ-010 SHALL have ports ar_valid out 1, ar_ready in 1, ar_addr out ADDR_WIDTH, ar_len out 8: AXI AR channel; ar_len = beats-1.
REQ-011 SHALL have port rlast_done  in  1: one-cycle pulse per R beat accepted with RLAST; retires one burst.
REQ-012 SHALL have port busy  out  1: high while a request is being split or any burst is outstanding.

Function
REQ-013 SHALL implement a state machine with states IDLE and ISSUE; req_ready=1 only in IDLE.
REQ-014 SHALL, on req_valid&req_ready with req_len!=0, latch addr (low log2(BYTES) bits forced 0) and remaining=req_len, then enter ISSUE.
REQ-015 SHALL accept a request with req_len==0 and remain in IDLE, issuing no burst.
REQ-016 SHALL set each burst's beats = min(remaining, MAX_BURST_LEN, beats to next 4 KB boundary).
REQ-017 SHALL present ar_addr/ar_len registered; they SHALL hold stable while ar_valid=1 and ar_ready=0.
REQ-018 SHALL, on ar_valid&ar_ready, advance addr by beats*BYTES and set remaining-=beats; at remaining==0 it SHALL return to IDLE the next cycle.
REQ-019 SHALL keep an outstanding counter (0..MAX_OUTSTANDING): +1 on AR handshake, -1 on rlast_done; both in the same cycle leaves it unchanged.
REQ-020 SHALL not assert a new ar_valid while the counter equals MAX_OUTSTANDING; an ar_valid already asserted SHALL not be withdrawn.
REQ-021 SHALL ignore rlast_done when the counter is 0 (no underflow).
REQ-022 SHALL drive busy = (state!=IDLE) | (outstanding!=0).
REQ-023 SHALL allow back-to-back bursts: one AR handshake per cycle when ar_ready=1 and there is counter headroom.

Reset
REQ-024 SHALL, on reset_n=0 at a clock edge, regardless of clk_en: state=IDLE, req_ready=1, ar_valid=0, ar_addr=0, ar_len=0, outstanding=0, busy=0.
REQ-025 SHALL, on reset mid-request, discard the remainder of the request; the first post-reset AR burst comes only from a new request.

Configuration
REQ-026 SHALL, with macro WQ_WEIGHT_M_AXI_4K_SPLIT_EN defined, apply the 4 KB term of REQ-016; without it, bursts SHALL be limited only by remaining and MAX_BURST_LEN.

Structure
REQ-027 SHALL take BYTES, the 4 KB constant (4096), and the state enum type from shared package weight_loader_m_axi_pkg.
REQ-028 SHALL use one combinational sub-module, weight_loader_wq_weight_mmap_m_axi_burst_calc, that computes the beats of the next burst.

Verification
REQ-029 SHALL cover a split request: addr 0x0, len 40, MAX_BURST_LEN 16, ar_ready=1 -> AR (0x000,15), (0x400,15), (0x800,7), then req_ready=1.
REQ-030 SHALL cover a 4 KB crossing: addr 0xF80, len 4 -> AR (0xF80,1), (0x1000,1); with the macro undefined -> a single AR (0xF80,3).
REQ-031 SHALL cover the outstanding limit: MAX_OUTSTANDING 2, len 64, no rlast_done -> exactly 2 AR handshakes, then ar_valid=0 until one rlast_done pulse, after which the 3rd AR issues.
REQ-032 SHALL cover backpressure: ar_ready=0 for 5 cycles on the first burst -> ar_valid, ar_addr and ar_len held constant; the handshake happens on the cycle ar_ready rises.
REQ-033 SHALL cover zero length and reset: len 0 -> no AR and busy stays 0; reset_n low after the 2nd of 3 bursts -> ar_valid=0, busy=0, and no further AR.
